// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: snapshots up to NSRC pixel-run requests per frame and paints them round-robin on LEDout.
// Define LEDSCHED_GHOST_BLANK_EN to insert BLANK_CYC dark cycles after every pixel.
module led_frame_scheduler #(
   parameter int NSRC      = 4,
   parameter int DWELL     = 16,
   parameter int BLANK_CYC = 2,
   parameter int FRAME_LEN = 2048
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [NSRC-1:0]   src_req,
   input  logic [2*NSRC-1:0] src_color,
   input  logic [4*NSRC-1:0] src_y,
   input  logic [3*NSRC-1:0] src_x,
   input  logic [2*NSRC-1:0] src_len,
   output logic [9:0]        LEDout,
   output logic              frame_start,
   output logic              busy,
   output logic              overrun,
   output logic [2:0]        cur_src
);
   localparam int FW = $clog2(FRAME_LEN);
   localparam int CW = $clog2(DWELL + BLANK_CYC + 1);
   typedef enum logic [2:0] {IDLE, LOAD, SELECT, SHOW, BLANK, DONE} state_t;
   state_t            state_q, state_d;
   logic [FW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     dcnt_q, dcnt_d;
   logic [2:0]        rp_q, rp_d, sel_q, sel_d, cur_q, cur_d, pick;
   logic [NSRC-1:0]   pend_q, pend_d, rot;
   logic [2*NSRC-1:0] color_q, len_q;
   logic [4*NSRC-1:0] y_q;
   logic [3*NSRC-1:0] x_q;
   logic [1:0]        cc_q, cc_d, cl_q, cl_d, k_q, k_d;
   logic [3:0]        cy_q, cy_d;
   logic [2:0]        cx_q, cx_d;
   logic [9:0]        led_q, led_d;
   logic              busy_q, busy_d, ovr_q, ovr_d, hit, more, wrap;
   assign frame_start = (cnt_q == '0);
   assign wrap        = (cnt_q == FW'(FRAME_LEN - 1));
   assign LEDout      = led_q;
   assign busy        = busy_q;
   assign overrun     = ovr_q;
   assign cur_src     = cur_q;
   // A further pixel exists only while inside the run and left of the matrix edge.
   assign more = (k_q < cl_q) && ({1'b0, cx_q} + {2'b00, k_q} + 4'd1 <= 4'd7);
   assign rot  = NSRC'({pend_q, pend_q} >> rp_q);
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (rot[k]) begin
            hit  = 1'b1;
            pick = 3'((int'(rp_q) + k) % NSRC);
         end
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      dcnt_d  = dcnt_q;
      rp_d    = rp_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      cc_d    = cc_q;
      cl_d    = cl_q;
      cy_d    = cy_q;
      cx_d    = cx_q;
      k_d     = k_q;
      ovr_d   = ovr_q;
      case (state_q)
         IDLE, LOAD: begin
            if (frame_start) begin
               state_d = SELECT;
               pend_d  = src_req;
            end
         end
         SELECT: begin
            if (hit) begin
               state_d = SHOW;
               sel_d   = pick;
               k_d     = '0;
               dcnt_d  = '0;
               pend_d  = pend_q & ~(NSRC'(1) << pick);
               for (int i = 0; i < NSRC; i++) begin
                  if (pick == 3'(i)) begin
                     cc_d = color_q[2*i +: 2];
                     cl_d = len_q[2*i +: 2];
                     cy_d = y_q[4*i +: 4];
                     cx_d = x_q[3*i +: 3];
                  end
               end
            end else begin
               state_d = DONE;
            end
         end
         SHOW: begin
            if (dcnt_q == CW'(DWELL - 1)) begin
               dcnt_d = '0;
`ifdef LEDSCHED_GHOST_BLANK_EN
               state_d = BLANK;
`else
               state_d = more ? SHOW : SELECT;
               k_d     = more ? k_q + 2'd1 : k_q;
`endif
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         BLANK: begin
            if (dcnt_q == CW'(BLANK_CYC - 1)) begin
               dcnt_d  = '0;
               state_d = more ? SHOW : SELECT;
               k_d     = more ? k_q + 2'd1 : k_q;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      // Next cycle is frame_start: abandon any unfinished schedule.
      if (wrap) begin
         state_d = LOAD;
         rp_d    = (rp_q == 3'(NSRC - 1)) ? '0 : rp_q + 3'd1;
         ovr_d   = ovr_q | (state_q != DONE);
      end
      led_d  = (state_d == SHOW) ? {cc_d, 1'b0, cy_d, cx_d + {1'b0, k_d}} : '0;
      cur_d  = (state_d == SHOW || state_d == BLANK) ? sel_d : '0;
      busy_d = (state_d == SHOW) || (state_d == BLANK) || (state_d == SELECT && pend_d != '0);
   end
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         rp_q    <= '0;
         sel_q   <= '0;
         pend_q  <= '0;
         cc_q    <= '0;
         cl_q    <= '0;
         cy_q    <= '0;
         cx_q    <= '0;
         k_q     <= '0;
         led_q   <= '0;
         cur_q   <= '0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         color_q <= '0;
         len_q   <= '0;
         y_q     <= '0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         rp_q    <= rp_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
         cc_q    <= cc_d;
         cl_q    <= cl_d;
         cy_q    <= cy_d;
         cx_q    <= cx_d;
         k_q     <= k_d;
         led_q   <= led_d;
         cur_q   <= cur_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         if (frame_start) begin
            color_q <= src_color;
            len_q   <= src_len;
            y_q     <= src_y;
            x_q     <= src_x;
         end
      end
   end
endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Time-multiplexed display scheduler owning the single 10-bit `LEDout` drive of the game board's 8×16 LED matrix. Up to `NSRC` requesters present a horizontal pixel run each: bars, ball, score markers. Once per frame the block snapshots all requests, then paints each requested pixel for a fixed dwell, in round-robin source order, with optional anti-ghost blanking. It replaces per-module hand-coded slot decoding, so game logic only supplies coordinates.

## Interface
Parameters:
- `NSRC`, 4: number of requesters (1–8).
- `DWELL`, 16: cycles each pixel is driven (≥1).
- `BLANK_CYC`, 2: blank cycles after each pixel (≥1).
- `FRAME_LEN`, 2048: frame period in cycles (≥4).

Ports:
- `CLK` in 1: clock.
- `RSTn` in 1: reset, asynchronous, active-low.
- `src_req` in NSRC: source i wants painting this frame.
- `src_color` in 2·NSRC: colour code of source i, in bits [2i+1:2i]; 2'b10 = bar, 2'b01 = ball.
- `src_y` in 4·NSRC: row 0–15.
- `src_x` in 3·NSRC: leftmost column 0–7.
- `src_len` in 2·NSRC: run length minus 1 (0–3 → 1–4 pixels).
- `LEDout` out 10: {colour[1:0], 1'b0, y[3:0], x[2:0]}; all-zero = dark.
- `frame_start` out 1: high while frame counter == 0.
- `busy` out 1: high from snapshot until last pixel/blank done.
- `overrun` out 1: sticky; frame ended before schedule completed.
- `cur_src` out 3: index of source being painted (0 when idle).

## Operation
- Free-running `frame_cnt` 0..FRAME_LEN-1, wraps to 0; `frame_start` = (frame_cnt == 0).
- FSM states:
  - IDLE: after reset only; goes to LOAD when `frame_start`.
  - LOAD: in the `frame_start` cycle, registers all `src_*` inputs into snapshot and sets pixel index to 0; goes to SELECT.
  - SELECT: one cycle. Picks the next snapshot source with req = 1, scanning from round-robin pointer `rp` upward modulo NSRC; each source is visited at most once per frame. Goes to SHOW if one is found, else DONE.
  - SHOW: drives the pixel for DWELL cycles; then BLANK.
  - BLANK: `LEDout` = 0 for BLANK_CYC cycles. Next pixel of the same run → SHOW. Run exhausted → SELECT.
  - DONE: `LEDout` = 0, `busy` = 0; goes to LOAD on next `frame_start`.
- Pixel k of a run is at column x+k, using 4-bit arithmetic. A pixel with x+k > 7 is clipped: it consumes zero cycles, and the run ends at the clip.
- `rp` increments modulo NSRC at every `frame_start` after the first.
- Inputs changing mid-frame have no effect until the next LOAD, so objects never tear.
- Overrun: if `frame_start` arrives while the state is not DONE, `overrun` ← 1. The remaining schedule is abandoned, `LEDout` goes to 0 in that cycle, and LOAD proceeds normally. `overrun` is cleared only by reset.
- Reset values: `LEDout` = 0, `busy` = 0, `overrun` = 0, `cur_src` = 0, `frame_cnt` = 0, `rp` = 0, state IDLE.
- Reset asserted mid-frame returns everything to reset values immediately; the first frame after release starts at frame_cnt 0.

## Timing
- Load/select latency: LOAD at frame_cnt 0, SELECT at 1, first pixel on `LEDout` during frame_cnt 2..DWELL+1.
- `LEDout` and `cur_src` are registered and change only on CLK rising edges. `cur_src` is valid throughout SHOW/BLANK.
- Per-pixel cost is DWELL+BLANK_CYC cycles. An extra SELECT cycle is added per source, not per pixel.
- A frame completes without overrun iff 2 + Σ_sources(1 + pixels·(DWELL+BLANK_CYC)) + 1 ≤ FRAME_LEN.

## Configuration
- `LEDSCHED_GHOST_BLANK_EN` defined: BLANK state is inserted as above.
- Undefined: BLANK is skipped, so SHOW goes straight to the next SHOW or SELECT. Per-pixel cost becomes DWELL, and `BLANK_CYC` is ignored.

## Test plan
Bench parameters: NSRC=4, DWELL=4, BLANK_CYC=1, FRAME_LEN=64; macro defined unless stated.
- Reset: hold RSTn low with random inputs → `LEDout` = 0, `busy` = 0, `overrun` = 0, `cur_src` = 0. Release mid-frame, then reassert → outputs return to 0 asynchronously.
- Single run: src0 req, colour 10, y=12, x=0, len=2 → 0x260 at cnt 2–5, 0 at 6, 0x261 at 7–10, 0 at 11, 0x262 at 12–15, 0 at 16. `busy` falls at 17.
- Clipping: src1 colour 01, y=3, x=6, len=3 → only 0x11E and 0x11F are painted. `busy` falls after 2 pixels.
- Round-robin: src0 and src2 each 1 pixel. Frame 0 order 0 then 2. Frame 1 (rp=1) order 2 then 0. Frame 2 (rp=2) order 2 then 0.
- Overrun: all 4 sources len=3 (16 pixels, 86 cycles > 64) → `overrun` rises at next `frame_start`, `LEDout` = 0 that cycle, and the next frame begins normally.
- Snapshot and macro: change src0 x from 0 to 5 at cnt 8 → the current frame still shows x=0..2 and the next shows x=5..7. With macro undefined → pixels back-to-back every 4 cycles with no zero gaps.
